mem_wb: RTL and testbench

- Final pipeline stage: memory access plus write-back.
- Accepts one retired-from-EX instruction per cycle and performs the data-memory load/store over a req/ack handshake.
- Stalls upstream stages while a memory access is outstanding.
- Drives the register-file write port consumed by the decode stage (wb_dest_en / wb_dest_reg / wb_dest_data).

---
 rtl/mem_wb_pkg.sv | 20 ++
 rtl/mem_wb_timeout.sv | 29 ++
 rtl/mem_wb.sv | 164 ++++++++++++++++
 tb/tb_mem_wb.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// Shared constants and FSM encoding for the memory/write-back stage.
package mem_wb_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned REG_IDX_W  = 5;
  localparam int unsigned DEST_SRC_W = 2;

  // Destination-source select values driven by EX
  localparam logic [DEST_SRC_W-1:0] DEST_SRC_NONE = 2'd0;
  localparam logic [DEST_SRC_W-1:0] DEST_SRC_ALU  = 2'd1;
  localparam logic [DEST_SRC_W-1:0] DEST_SRC_MEM  = 2'd2;
  localparam logic [DEST_SRC_W-1:0] DEST_SRC_LINK = 2'd3;

  typedef enum logic [0:0] {
    MWB_IDLE = 1'b0,
    MWB_REQ  = 1'b1
  } mwb_state_t;

endpackage

// File: rtl/mem_wb_timeout.sv
// Memory-ack watchdog: counts REQ cycles without ack, flags the last allowed cycle.
module mem_wb_timeout #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic aresetn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] count;

  // Cycle counter with synchronous clear taking priority over increment
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_wb.sv
// Final pipeline stage: data-memory access over req/ack plus register write-back.
module mem_wb
  import mem_wb_pkg::*;
#(
  parameter int unsigned ADDR_W      = mem_wb_pkg::ADDR_W,
  parameter int unsigned WORD_W      = mem_wb_pkg::WORD_W,
  parameter int unsigned REG_IDX_W   = mem_wb_pkg::REG_IDX_W,
  parameter int unsigned DEST_SRC_W  = mem_wb_pkg::DEST_SRC_W,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  clr,
  input  logic                  i_valid,
  input  logic [ADDR_W-1:0]     i_pc,
  input  logic [DEST_SRC_W-1:0] i_dest_src,
  input  logic [REG_IDX_W-1:0]  i_dest_reg,
  input  logic [WORD_W-1:0]     i_alu_result,
  input  logic                  i_mem_we,
  input  logic [WORD_W-1:0]     i_store_data,
  output logic                  o_stall,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [WORD_W-1:0]     o_mem_wdata,
  input  logic                  i_mem_ack,
  input  logic [WORD_W-1:0]     i_mem_rdata,
  output logic                  o_wb_dest_en,
  output logic [REG_IDX_W-1:0]  o_wb_dest_reg,
  output logic [WORD_W-1:0]     o_wb_dest_data,
  output logic                  o_mem_err
);

  mwb_state_t             state, state_next;
  logic                   mem_we, we_next;
  logic [ADDR_W-1:0]      mem_addr, addr_next;
  logic [WORD_W-1:0]      mem_wdata, wdata_next;
  logic                   pend_load, pend_load_next;
  logic [REG_IDX_W-1:0]   pend_reg, pend_reg_next;
  logic                   wb_en, wb_en_next;
  logic [REG_IDX_W-1:0]   wb_reg, wb_reg_next;
  logic [WORD_W-1:0]      wb_data, wb_data_next;
  logic                   err, err_next;
  logic                   cnt_clr, cnt_en, expired;
  logic                   is_mem;

  assign is_mem = (i_dest_src == DEST_SRC_W'(DEST_SRC_MEM)) || i_mem_we;

  mem_wb_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .aresetn (aresetn),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (expired)
  );

  // Next-state, request latching and write-back selection; flush overrides all
  always_comb begin
    state_next     = state;
    we_next        = mem_we;
    addr_next      = mem_addr;
    wdata_next     = mem_wdata;
    pend_load_next = pend_load;
    pend_reg_next  = pend_reg;
    wb_en_next     = 1'b0;
    wb_reg_next    = wb_reg;
    wb_data_next   = wb_data;
    err_next       = 1'b0;
    cnt_clr        = 1'b0;
    cnt_en         = 1'b0;

    if (clr) begin
      state_next = MWB_IDLE;
      we_next    = 1'b0;
    end else begin
      case (state)
        MWB_IDLE: begin
          if (i_valid) begin
            if (is_mem) begin
              state_next     = MWB_REQ;
              we_next        = i_mem_we;
              addr_next      = ADDR_W'(i_alu_result);
              wdata_next     = i_store_data;
              pend_load_next = !i_mem_we;
              pend_reg_next  = i_dest_reg;
              cnt_clr        = 1'b1;
            end else begin
              wb_reg_next = i_dest_reg;
              if (i_dest_src == DEST_SRC_W'(DEST_SRC_ALU)) begin
                wb_en_next   = (i_dest_reg != '0);
                wb_data_next = i_alu_result;
              end else if (i_dest_src == DEST_SRC_W'(DEST_SRC_LINK)) begin
                wb_en_next   = (i_dest_reg != '0);
                wb_data_next = WORD_W'(i_pc) + WORD_W'(4);
              end
            end
          end
        end
        MWB_REQ: begin
          // Ack on the expiry cycle still completes normally
          if (i_mem_ack) begin
            state_next = MWB_IDLE;
            we_next    = 1'b0;
            if (pend_load) begin
              wb_en_next   = (pend_reg != '0);
              wb_reg_next  = pend_reg;
              wb_data_next = i_mem_rdata;
            end
          end else if (expired) begin
            state_next = MWB_IDLE;
            we_next    = 1'b0;
            err_next   = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end
        default: begin
          state_next = MWB_IDLE;
          we_next    = 1'b0;
        end
      endcase
    end
  end

  // Pipeline state and registered outputs
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= MWB_IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      pend_load <= 1'b0;
      pend_reg  <= '0;
      wb_en     <= 1'b0;
      wb_reg    <= '0;
      wb_data   <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_next;
      mem_we    <= we_next;
      mem_addr  <= addr_next;
      mem_wdata <= wdata_next;
      pend_load <= pend_load_next;
      pend_reg  <= pend_reg_next;
      wb_en     <= wb_en_next;
      wb_reg    <= wb_reg_next;
      wb_data   <= wb_data_next;
      err       <= err_next;
    end
  end

  assign o_stall        = (state == MWB_REQ);
  assign o_mem_req      = (state == MWB_REQ);
  assign o_mem_we       = mem_we;
  assign o_mem_addr     = mem_addr;
  assign o_mem_wdata    = mem_wdata;
  assign o_wb_dest_en   = wb_en;
  assign o_wb_dest_reg  = wb_reg;
  assign o_wb_dest_data = wb_data;
  assign o_mem_err      = err;

endmodule

// File: tb/tb_mem_wb.sv
// Directed self-checking bench for mem_wb.
module tb_mem_wb;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        clr;
  logic        i_valid;
  logic [31:0] i_pc;
  logic [1:0]  i_dest_src;
  logic [4:0]  i_dest_reg;
  logic [31:0] i_alu_result;
  logic        i_mem_we;
  logic [31:0] i_store_data;
  logic        o_stall;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        o_wb_dest_en;
  logic [4:0]  o_wb_dest_reg;
  logic [31:0] o_wb_dest_data;
  logic        o_mem_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb #(
    .TIMEOUT_CYC (16)
  ) dut (
    .clk            (clk),
    .aresetn        (aresetn),
    .clr            (clr),
    .i_valid        (i_valid),
    .i_pc           (i_pc),
    .i_dest_src     (i_dest_src),
    .i_dest_reg     (i_dest_reg),
    .i_alu_result   (i_alu_result),
    .i_mem_we       (i_mem_we),
    .i_store_data   (i_store_data),
    .o_stall        (o_stall),
    .o_mem_req      (o_mem_req),
    .o_mem_we       (o_mem_we),
    .o_mem_addr     (o_mem_addr),
    .o_mem_wdata    (o_mem_wdata),
    .i_mem_ack      (i_mem_ack),
    .i_mem_rdata    (i_mem_rdata),
    .o_wb_dest_en   (o_wb_dest_en),
    .o_wb_dest_reg  (o_wb_dest_reg),
    .o_wb_dest_data (o_wb_dest_data),
    .o_mem_err      (o_mem_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_valid      = 1'b0;
    i_dest_src   = 2'd0;
    i_dest_reg   = '0;
    i_alu_result = '0;
    i_mem_we     = 1'b0;
    i_store_data = '0;
    i_pc         = '0;
  endtask

  task automatic present(input logic [1:0] src, input logic [4:0] rd,
                         input logic [31:0] alu, input logic we,
                         input logic [31:0] sd, input logic [31:0] pc);
    i_valid      = 1'b1;
    i_dest_src   = src;
    i_dest_reg   = rd;
    i_alu_result = alu;
    i_mem_we     = we;
    i_store_data = sd;
    i_pc         = pc;
  endtask

  initial begin
    int n;
    int stall_seen;
    aresetn     = 1'b0;
    clr         = 1'b0;
    i_mem_ack   = 1'b0;
    i_mem_rdata = '0;
    idle_inputs();
    tick();
    tick();
    check("rst_req",   {31'd0, o_mem_req},    32'd0);
    check("rst_stall", {31'd0, o_stall},      32'd0);
    check("rst_wb_en", {31'd0, o_wb_dest_en}, 32'd0);
    check("rst_data",  o_wb_dest_data,        32'd0);
    check("rst_err",   {31'd0, o_mem_err},    32'd0);
    @(negedge clk);
    aresetn = 1'b1;
    tick();

    // ALU op: 1-cycle write-back, never stalls
    present(2'd1, 5'd5, 32'h1234, 1'b0, '0, '0);
    stall_seen = int'(o_stall);
    tick();
    idle_inputs();
    stall_seen += int'(o_stall);
    check("alu_en",    {31'd0, o_wb_dest_en}, 32'd1);
    check("alu_reg",   {27'd0, o_wb_dest_reg}, 32'd5);
    check("alu_data",  o_wb_dest_data,         32'h1234);
    tick();
    stall_seen += int'(o_stall);
    check("alu_stall", stall_seen,             32'd0);
    check("alu_en_off", {31'd0, o_wb_dest_en}, 32'd0);

    // Load, ack on third REQ cycle, then back-to-back ALU op
    present(2'd2, 5'd7, 32'h100, 1'b0, '0, '0);
    tick();
    idle_inputs();
    check("ld_addr", o_mem_addr,          32'h100);
    check("ld_we",   {31'd0, o_mem_we},   32'd0);
    n = 0;
    stall_seen = 0;
    for (int c = 0; c < 3; c++) begin
      n += int'(o_mem_req);
      stall_seen += int'(o_stall);
      check("ld_no_wb", {31'd0, o_wb_dest_en}, 32'd0);
      if (c == 2) begin
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'hDEADBEEF;
      end
      tick();
    end
    i_mem_ack   = 1'b0;
    i_mem_rdata = '0;
    check("ld_req_cycles",   n,          32'd3);
    check("ld_stall_cycles", stall_seen, 32'd3);
    check("ld_req_drop",  {31'd0, o_mem_req},    32'd0);
    check("ld_wb_en",     {31'd0, o_wb_dest_en}, 32'd1);
    check("ld_wb_reg",    {27'd0, o_wb_dest_reg}, 32'd7);
    check("ld_wb_data",   o_wb_dest_data,         32'hDEADBEEF);
    present(2'd1, 5'd2, 32'h77, 1'b0, '0, '0);
    tick();
    idle_inputs();
    check("b2b_en",   {31'd0, o_wb_dest_en}, 32'd1);
    check("b2b_data", o_wb_dest_data,        32'h77);
    check("b2b_req",  {31'd0, o_mem_req},    32'd0);
    tick();

    // Store, ack in first REQ cycle
    present(2'd0, 5'd0, 32'h40, 1'b1, 32'hA5A5A5A5, '0);
    tick();
    idle_inputs();
    check("st_req",   {31'd0, o_mem_req}, 32'd1);
    check("st_we",    {31'd0, o_mem_we},  32'd1);
    check("st_addr",  o_mem_addr,         32'h40);
    check("st_wdata", o_mem_wdata,        32'hA5A5A5A5);
    i_mem_ack = 1'b1;
    tick();
    i_mem_ack = 1'b0;
    check("st_req_drop", {31'd0, o_mem_req},    32'd0);
    check("st_we_drop",  {31'd0, o_mem_we},     32'd0);
    check("st_no_wb",    {31'd0, o_wb_dest_en}, 32'd0);
    tick();

    // Timeout: never ack
    present(2'd2, 5'd3, 32'h200, 1'b0, '0, '0);
    tick();
    idle_inputs();
    n = 0;
    while (o_mem_req && n < 40) begin
      n++;
      if (o_mem_err || o_wb_dest_en) check("to_early", 32'd1, 32'd0);
      tick();
    end
    check("to_req_cycles", n,                      32'd16);
    check("to_err",        {31'd0, o_mem_err},     32'd1);
    check("to_no_wb",      {31'd0, o_wb_dest_en},  32'd0);
    check("to_stall",      {31'd0, o_stall},       32'd0);
    tick();
    check("to_err_pulse",  {31'd0, o_mem_err},     32'd0);
    present(2'd1, 5'd9, 32'h55, 1'b0, '0, '0);
    tick();
    idle_inputs();
    check("to_alu_en",   {31'd0, o_wb_dest_en}, 32'd1);
    check("to_alu_data", o_wb_dest_data,        32'h55);
    tick();

    // clr during REQ, then late ack
    present(2'd2, 5'd4, 32'h300, 1'b0, '0, '0);
    tick();
    idle_inputs();
    tick();
    check("clr_pre_req", {31'd0, o_mem_req}, 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_req",   {31'd0, o_mem_req},    32'd0);
    check("clr_stall", {31'd0, o_stall},      32'd0);
    check("clr_wb",    {31'd0, o_wb_dest_en}, 32'd0);
    check("clr_err",   {31'd0, o_mem_err},    32'd0);
    i_mem_ack   = 1'b1;
    i_mem_rdata = 32'hCAFEF00D;
    tick();
    i_mem_ack   = 1'b0;
    check("late_ack_wb",  {31'd0, o_wb_dest_en}, 32'd0);
    check("late_ack_req", {31'd0, o_mem_req},    32'd0);
    present(2'd1, 5'd0, 32'hFFFF, 1'b0, '0, '0);
    tick();
    idle_inputs();
    check("r0_wb_en", {31'd0, o_wb_dest_en}, 32'd0);

    // LINK wraps modulo 2^32
    present(2'd3, 5'd1, 32'h0, 1'b0, '0, 32'hFFFFFFFC);
    tick();
    idle_inputs();
    check("link_en",   {31'd0, o_wb_dest_en}, 32'd1);
    check("link_reg",  {27'd0, o_wb_dest_reg}, 32'd1);
    check("link_data", o_wb_dest_data,         32'h0);
    tick();

    // Asynchronous reset in the middle of a load
    present(2'd2, 5'd6, 32'h400, 1'b0, '0, '0);
    tick();
    idle_inputs();
    check("ar_pre_req", {31'd0, o_mem_req}, 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    check("ar_req",   {31'd0, o_mem_req},    32'd0);
    check("ar_stall", {31'd0, o_stall},      32'd0);
    check("ar_addr",  o_mem_addr,            32'd0);
    check("ar_wb",    {31'd0, o_wb_dest_en}, 32'd0);
    check("ar_err",   {31'd0, o_mem_err},    32'd0);
    @(negedge clk);
    aresetn = 1'b1;
    tick();
    check("ar_idle_req", {31'd0, o_mem_req}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
